// File: rtl/fft_sequencer.sv
// fft_sequencer: drives one shared radix-2 butterfly through an 8-point
// DIT FFT, with bit-reversed load, in-place update and natural-order unload.
module fft_sequencer #(
    parameter int LOG2N    = 3,
    parameter int WIDTH    = 8,
    parameter int BFLY_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*WIDTH-1:0]   in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_data,
    input  logic                 out_ready,
    output logic                 bf_valid,
    output logic [2*WIDTH-1:0]   bf_a,
    output logic [2*WIDTH-1:0]   bf_b,
    output logic [LOG2N-1:0]     twiddle_idx,
    input  logic [2*WIDTH-1:0]   bf_y0,
    input  logic [2*WIDTH-1:0]   bf_y1,
    output logic                 busy,
    output logic                 done
);
    localparam int N  = 1 << LOG2N;
    localparam int DW = 2 * WIDTH;

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    localparam logic [2:0]       LAT  = 3'(BFLY_LAT);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       k_q, k_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [LOG2N-1:0] a_q, a_d;
    logic [LOG2N-1:0] b_q, b_d;
    logic [DW-1:0]    mem_q [N];
    logic [DW-1:0]    mem_d [N];

    logic [LOG2N-1:0] addr_a, addr_b, tw;

    // Operand pair and twiddle for stage s, butterfly k
    always_comb begin
        addr_a = '0;
        addr_b = '0;
        tw     = '0;
        unique case (s_q)
            2'd0: begin
                addr_a = {k_q, 1'b0};
                addr_b = addr_a | 3'd1;
            end
            2'd1: begin
                addr_a = {k_q[1], 1'b0, k_q[0]};
                addr_b = addr_a | 3'd2;
                tw     = {1'b0, k_q[0], 1'b0};
            end
            default: begin
                addr_a = {1'b0, k_q};
                addr_b = addr_a | 3'd4;
                tw     = {1'b0, k_q};
            end
        endcase
    end

    // Sequencer next-state, outputs and working-store updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        k_d         = k_q;
        wcnt_d      = wcnt_q;
        a_d         = a_q;
        b_d         = b_q;
        mem_d       = mem_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        bf_valid    = 1'b0;
        bf_a        = '0;
        bf_b        = '0;
        twiddle_idx = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && !rst) begin
                    mem_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_ISSUE;
                        s_d     = '0;
                        k_d     = '0;
                    end
                end
            end
            S_ISSUE: begin
                busy        = 1'b1;
                bf_valid    = 1'b1;
                bf_a        = mem_q[addr_a];
                bf_b        = mem_q[addr_b];
                twiddle_idx = tw;
                a_d         = addr_a;
                b_d         = addr_b;
                wcnt_d      = LAT;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wcnt_q == 3'd1) begin
                    if (!rst) begin
                        mem_d[a_q] = bf_y0;
                        mem_d[b_q] = bf_y1;
                    end
                    k_d = k_q + 1'b1;
                    if (k_q == 2'd3) begin
                        s_d = s_q + 1'b1;
                    end
                    if (s_q == 2'd2 && k_q == 2'd3) begin
                        state_d = S_UNLOAD;
                        s_d     = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: begin
                out_valid = 1'b1;
                out_data  = mem_q[cnt_q];
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        done    = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            wcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Working store keeps its contents across reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Controller that runs a complete 8-point radix-2 DIT FFT on one shared butterfly unit, one butterfly at a time.
- Accepts 8 complex samples from the UART receive path and stores them in bit-reversed order in an internal 8×16 working store.
- Issues 12 butterflies (3 stages × 4), supplying operands and twiddle index and writing results back in place.
- Streams the 8 results out in natural order to the transmit path with valid/ready backpressure.

Parameters:
- LOG2N, 3, log2 of transform length; fixed at 3 (N=8) for this release.
- WIDTH, 8, bits per real/imag component; a complex word is 2*WIDTH bits.
- BFLY_LAT, 1, butterfly latency in cycles from issue to result; legal values are 1..4.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_data  in  2*WIDTH  input sample, {re[15:8], im[7:0]}.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  result valid.
- out_data  out  2*WIDTH  result {re, im}; 0 when out_valid=0.
- out_ready  in  1  downstream accept.
- bf_valid  out  1  one-cycle butterfly issue strobe.
- bf_a  out  2*WIDTH  butterfly top operand; 0 when bf_valid=0.
- bf_b  out  2*WIDTH  butterfly bottom operand; 0 when bf_valid=0.
- twiddle_idx  out  LOG2N  twiddle LUT index; 0 when bf_valid=0.
- bf_y0  in  2*WIDTH  butterfly top result.
- bf_y1  in  2*WIDTH  butterfly bottom result.
- busy  out  1  high in ISSUE or WAIT.
- done  out  1  one-cycle pulse on the last output handshake.

Behaviour:
- Reset (any state): state=LOAD; all counters 0; in_ready=1; out_valid=0; bf_valid=0; done=0; busy=0; bf_a/bf_b/twiddle_idx=0. Working store is not cleared. Reset mid-compute or mid-unload abandons the frame entirely.
- States: LOAD → ISSUE ⇄ WAIT → UNLOAD → LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write mem[bitrev3(cnt)]=in_data and increment cnt.
  - The 8th accept moves to ISSUE next cycle, with stage s=0 and butterfly k=0.
- Addressing for stage s and butterfly k (0..3):
  - span=1<<s; pos=k&(span-1).
  - a=((k>>s)<<(s+1))+pos; b=a+span.
  - twiddle_idx=pos<<(2-s).
- ISSUE (1 cycle):
  - bf_valid=1; bf_a=mem[a]; bf_b=mem[b]; twiddle_idx as above.
  - Latch a and b; load the wait counter with BFLY_LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where it reaches 1 (BFLY_LAT cycles after issue), bf_y0 and bf_y1 are valid; the controller writes mem[a]=bf_y0 and mem[b]=bf_y1 at that clock edge.
  - Then advance k. On k wrap 3→0, advance s. After s=2,k=3 go to UNLOAD; otherwise go to ISSUE.
- Throughput: each butterfly takes BFLY_LAT+1 cycles, so a full frame takes 12*(BFLY_LAT+1) cycles. There is no overlap between butterflies, so no read-after-write hazard.
- UNLOAD:
  - out_valid=1; out_data=mem[cnt].
  - cnt advances only on out_valid&&out_ready.
  - While out_ready=0, out_data is held stable.
  - The 8th handshake pulses done and returns to LOAD with cnt=0 next cycle.
- Port isolation:
  - in_valid outside LOAD is ignored and nothing is written.
  - bf_y0/bf_y1 are ignored outside the write cycle.
  - out_ready outside UNLOAD is ignored.
- Arithmetic (scaling, overflow) is owned entirely by the butterfly. The sequencer never modifies data.

Test Plan:
- Bench butterfly stub: y0=a+b, y1=a−b, per-byte modulo 256, twiddle ignored, with the configured BFLY_LAT.
- Load order: input x[i]={i,0}, i=0..7 → first issue has bf_a=0x0000 and bf_b=0x0400 (mem[1]=x[4]). twiddle_idx=0 for all stage-0 issues.
- Issue sequence: record (a operand origin, b operand origin, twiddle_idx) per issue → stage0 (0,1,0)(2,3,0)(4,5,0)(6,7,0); stage1 (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage2 (0,4,0)(1,5,1)(2,6,2)(3,7,3).
- Impulse with BFLY_LAT=1: x[0]=0x0100, others 0 → all 8 outputs 0x0100. First out_valid is exactly 25 cycles after the cycle of the 8th input accept. done pulses once.
- Backpressure: hold out_ready=0 for 5 cycles at output 3 → out_valid stays 1, out_data is stable, no skipped or duplicated words. Also assert in_valid during UNLOAD → in_ready=0 and the frame is unaffected.
- BFLY_LAT=3, all inputs 0x0101 → output0=0x0808, outputs 1..7=0x0000. busy stays high for exactly 48 cycles.
- Assert rst for 1 cycle mid-stage-1 → next cycle state=LOAD, in_ready=1, bf_valid=0. A fresh impulse frame afterwards gives a correct result.
